// File: rtl/idc_arbiter_if.sv
// Bundle of requester, response and shared-checker signals for idc_arbiter.
// slave: the arbiter side; master: requesters plus checker model driving it.
interface idc_arbiter_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [5:0] req0_id;
  logic [5:0] req1_id;
  logic       req0_ready;
  logic       req1_ready;
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic       rsp_legal;
  logic       rsp_err;
  logic       idc_in_valid;
  logic [5:0] idc_in_id;
  logic       idc_out_valid;
  logic       idc_out_legal;
  logic       busy;

  modport slave (
    input  req0_valid, req1_valid, req0_id, req1_id, idc_out_valid, idc_out_legal,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_legal, rsp_err,
           idc_in_valid, idc_in_id, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_id, req1_id, idc_out_valid, idc_out_legal,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_legal, rsp_err,
           idc_in_valid, idc_in_id, busy
  );
endinterface

// File: rtl/idc_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ID checker.
// Optional WAIT timeout is enabled by defining IDC_ARB_TIMEOUT_EN.
module idc_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input logic          clk,
  input logic          rst_n,
  idc_arbiter_if.slave bus
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("idc_arbiter: TIMEOUT_CYC must be in 2..255");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic       owner_q, owner_d;
  logic       legal_q, legal_d;
  logic [5:0] id_q, id_d;
  logic       grant0, grant1;

`ifdef IDC_ARB_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
`endif

  // rr names the requester that wins when both are valid.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | rr_q);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    legal_d = legal_q;
    id_d    = id_q;
`ifdef IDC_ARB_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          state_d = StIssue;
          owner_d = grant1;
          id_d    = grant1 ? bus.req1_id : bus.req0_id;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef IDC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // A result arriving in the expiry cycle still counts as a normal result.
        if (bus.idc_out_valid) begin
          state_d = StResp;
          legal_d = bus.idc_out_legal;
`ifdef IDC_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d = StResp;
          legal_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      StResp: begin
        state_d = StIdle;
        rr_d    = ~owner_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      legal_q <= 1'b0;
      id_q    <= '0;
`ifdef IDC_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      legal_q <= legal_d;
      id_q    <= id_d;
`ifdef IDC_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // ready is gated by rst_n so nothing is offered while reset is held.
  assign bus.req0_ready   = rst_n & (state_q == StIdle) & grant0;
  assign bus.req1_ready   = rst_n & (state_q == StIdle) & grant1;
  assign bus.idc_in_valid = (state_q == StIssue);
  assign bus.idc_in_id    = id_q;
  assign bus.rsp0_valid   = (state_q == StResp) & ~owner_q;
  assign bus.rsp1_valid   = (state_q == StResp) & owner_q;
  assign bus.rsp_legal    = (state_q == StResp) & legal_q;
`ifdef IDC_ARB_TIMEOUT_EN
  assign bus.rsp_err      = (state_q == StResp) & err_q;
`else
  assign bus.rsp_err      = 1'b0;
`endif
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_idc_arbiter.sv
// Self-checking bench for idc_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_idc_arbiter;
  localparam int unsigned TimeoutCyc = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   rr_model;  // requester favoured when both are valid

  idc_arbiter_if bus ();

  idc_arbiter #(
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                  bus.rsp_legal, bus.rsp_err, bus.idc_in_valid, bus.idc_in_id, bus.busy}),
        32'd0);
  endtask

  // One full transaction: accept, issue, wait lat cycles for the checker, respond.
  task automatic run_txn(input bit v0, input bit v1, input logic [5:0] id0,
                         input logic [5:0] id1, input int lat, input bit legal);
    bit         owner;
    logic [5:0] exp_id;
    owner  = (v0 && v1) ? rr_model : !v0;
    exp_id = owner ? id1 : id0;

    @(negedge clk);
    bus.req0_valid    = v0;
    bus.req1_valid    = v1;
    bus.req0_id       = id0;
    bus.req1_id       = id1;
    bus.idc_out_valid = 1'($urandom_range(0, 1));
    bus.idc_out_legal = 1'($urandom_range(0, 1));
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("grant", 32'({bus.req1_ready, bus.req0_ready}), owner ? 32'd2 : 32'd1);

    @(negedge clk);
    bus.req0_id       = 6'($urandom_range(0, 63));
    bus.req1_id       = 6'($urandom_range(0, 63));
    bus.idc_out_valid = 1'($urandom_range(0, 1));
    #1;
    chk("issue_valid", 32'(bus.idc_in_valid), 32'd1);
    chk("issue_id", 32'(bus.idc_in_id), 32'(exp_id));
    chk("issue_ready", 32'({bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid}),
        32'd0);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.idc_out_valid = (k == lat);
      bus.idc_out_legal = (k == lat) ? legal : 1'($urandom_range(0, 1));
      #1;
      chk("wait_state", 32'({bus.busy, bus.idc_in_valid, bus.rsp1_valid, bus.rsp0_valid,
                             bus.req1_ready, bus.req0_ready}), 32'b100000);
      chk("wait_id_hold", 32'(bus.idc_in_id), 32'(exp_id));
    end

    @(negedge clk);
    bus.idc_out_valid = 1'($urandom_range(0, 1));
    bus.idc_out_legal = 1'($urandom_range(0, 1));
    #1;
    chk("rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), owner ? 32'd2 : 32'd1);
    chk("rsp_legal", 32'(bus.rsp_legal), 32'(legal));
    chk("rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rsp_busy", 32'(bus.busy), 32'd1);
    rr_model = !owner;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rr_model          = 1'b0;
    rst_n             = 1'b0;
    bus.req0_valid    = 1'b1;
    bus.req1_valid    = 1'b1;
    bus.req0_id       = 6'd10;
    bus.req1_id       = 6'd20;
    bus.idc_out_valid = 1'b0;
    bus.idc_out_legal = 1'b0;

    // Reset held with both requesters valid: every output low.
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset_outputs");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both valid in the first cycle after reset, then alternation while both stay valid.
    run_txn(1'b1, 1'b1, 6'd10, 6'd20, 2, 1'b1);
    run_txn(1'b1, 1'b1, 6'd10, 6'd20, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    // Single requester, checker latency 3.
    run_txn(1'b1, 1'b0, 6'd5, 6'd0, 3, 1'b1);

    // Checker result while idle is ignored.
    @(negedge clk);
    bus.req0_valid    = 1'b0;
    bus.req1_valid    = 1'b0;
    bus.idc_out_valid = 1'b1;
    bus.idc_out_legal = 1'b1;
    #1;
    chk("idle_pulse_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.idc_out_valid = 1'b0;
    #1;
    chk("idle_pulse_norsp", 32'({bus.busy, bus.rsp1_valid, bus.rsp0_valid}), 32'd0);

`ifdef IDC_ARB_TIMEOUT_EN
    // Silent checker: error response TimeoutCyc cycles after WAIT entry.
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_id    = 6'd33;
    #1;
    chk("to_grant", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    for (int k = 1; k <= int'(TimeoutCyc); k++) begin
      @(negedge clk);
      #1;
      chk("to_wait", 32'({bus.busy, bus.rsp1_valid, bus.rsp0_valid}), 32'b100);
    end
    @(negedge clk);
    bus.idc_out_valid = 1'b1;
    bus.idc_out_legal = 1'b1;
    #1;
    chk("to_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_legal, bus.rsp_err}),
        32'b1001);
    rr_model = 1'b0;
    @(negedge clk);
    #1;
    chk("to_late_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.idc_out_valid = 1'b0;
    #1;
    chk("to_late_ignored", 32'({bus.busy, bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    // Result in the expiry cycle wins over the timeout.
    run_txn(1'b1, 1'b0, 6'd7, 6'd0, int'(TimeoutCyc), 1'b1);
    run_txn(1'b0, 1'b1, 6'd0, 6'd9, int'(TimeoutCyc) - 1, 1'b1);
`else
    // No timeout: a long-silent checker just keeps the arbiter busy.
    run_txn(1'b0, 1'b1, 6'd0, 6'd33, 21, 1'b1);
`endif

    // Reset in WAIT: discard the transaction, pointer back to req0.
    run_txn(1'b1, 1'b0, 6'd1, 6'd0, 1, 1'b1);
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_id    = 6'd40;
    bus.req1_id    = 6'd41;
    #1;
    chk("rst_pre_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
    repeat (2) @(negedge clk);
    rst_n             = 1'b0;
    bus.idc_out_valid = 1'b1;
    bus.idc_out_legal = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    #1;
    chk_all_zero("rst_held");
    bus.idc_out_valid = 1'b0;
    rr_model          = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_txn(1'b1, 1'b1, 6'd40, 6'd41, 2, 1'b0);

    // Randomized traffic against the round-robin model.
    for (int i = 0; i < 16; i++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(v0, v1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/idc_arbiter.md
IDC_ARBITER -- requirements
Module: idc_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 32, giving the WAIT-state cycle limit (used only with IDC_ARB_TIMEOUT_EN); legal range 2..255.
REQ-002 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid, req1_valid  input  1  requester N presents an ID.
REQ-005 The block SHALL have ports req0_id, req1_id  input  6  ID to be checked.
REQ-006 The block SHALL have ports req0_ready, req1_ready  output  1  ID accepted this cycle when valid&ready.
REQ-007 The block SHALL have ports rsp0_valid, rsp1_valid  output  1  one-cycle result pulse to requester N, no backpressure.
REQ-008 The block SHALL have port rsp_legal  output  1  check result, qualified by rspN_valid.
REQ-009 The block SHALL have port rsp_err  output  1  timeout indication, qualified by rspN_valid.
REQ-010 The block SHALL have ports idc_in_valid  output  1, idc_in_id  output  6: issue to the shared ID checker.
REQ-011 The block SHALL have ports idc_out_valid  input  1, idc_out_legal  input  1: checker result.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; transitions IDLE->ISSUE on accept, ISSUE->WAIT always, WAIT->RESP on result, RESP->IDLE always.
REQ-014 In IDLE, grant SHALL be combinational: only one valid -> that requester; both valid -> requester selected by the round-robin pointer rr.
REQ-015 reqN_ready SHALL equal (state==IDLE) & grantN; it SHALL be 0 in all other states.
REQ-016 On accept, the ID and owner SHALL be latched; later changes on reqN_id are ignored.
REQ-017 In ISSUE, idc_in_valid SHALL be 1 for exactly one cycle with idc_in_id = latched ID; idc_in_id SHALL hold its value otherwise.
REQ-018 In WAIT, idc_out_valid=1 SHALL capture idc_out_legal and move to RESP; idc_out_valid in IDLE/ISSUE/RESP SHALL be ignored.
REQ-019 In RESP, rsp<owner>_valid SHALL pulse for one cycle with rsp_legal = captured value; the other rsp valid stays 0.
REQ-020 In RESP, rr SHALL be set to the requester not served.
REQ-021 Latency: accept at cycle T, idc_in_valid at T+1, checker result at T+1+L (L>=1), rsp pulse at T+2+L; minimum 4 cycles per transaction.
REQ-022 At most one transaction SHALL be outstanding to the checker.

Reset
REQ-023 On rst_n low, state SHALL go to IDLE immediately; rr=0; latched ID, idc_in_id, captured result = 0.
REQ-024 During reset all outputs SHALL be 0; in-flight transactions are discarded with no response.
REQ-025 After reset deassertion, the first cycle SHALL be IDLE with no pending state.

Configuration
REQ-026 With IDC_ARB_TIMEOUT_EN defined, a counter cleared on WAIT entry SHALL count WAIT cycles; after TIMEOUT_CYC WAIT cycles without idc_out_valid, the FSM SHALL go to RESP with rsp_legal=0, rsp_err=1.
REQ-027 With IDC_ARB_TIMEOUT_EN, idc_out_valid in the same cycle as expiry SHALL win (normal result, rsp_err=0); a late result after timeout SHALL be ignored.
REQ-028 Without IDC_ARB_TIMEOUT_EN, WAIT SHALL persist until idc_out_valid, rsp_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-029 Single req0_id=6'd5 accepted at T, checker L=3 legal=1 -> idc_in_valid/id=5 at T+1, rsp0_valid=1 with rsp_legal=1 at T+5.
REQ-030 Both valid in first cycle after reset, ids 6'd10/6'd20 -> req0 served first (idc_in_id=10), then req1 (20); rsp0 precedes rsp1.
REQ-031 Both held valid for 4 transactions -> grants alternate 0,1,0,1; busy low exactly one cycle between transactions.
REQ-032 TIMEOUT_CYC=8, macro defined, checker silent -> rsp_err=1, rsp_legal=0 8 cycles after WAIT entry; later idc_out_valid ignored; macro undefined -> busy stays high.
REQ-033 rst_n pulsed low in WAIT -> all outputs 0 asynchronously, no rsp pulse; next simultaneous request grants req0.
REQ-034 idc_out_valid=1 pulsed while IDLE -> no rsp pulse, state unchanged.
